// File: rtl/riscv_dm_pkg.sv
// ----------------------------------------------------------------------------
// riscv_dm_pkg
// Shared types for the RISC-V Debug Module and its AXI4-Lite to SRI bridge.
//
// Contents:
//   axi_resp_t          - 2-bit AXI response code plus OKAY/SLVERR/DECERR
//   sri_bridge_state_t  - bridge FSM states (IDLE, ISSUE, CAPTURE, RESP)
//   SRI_DATA_WIDTH      - data width of the SRI responder port
//   SRI_BE_WIDTH        - byte-enable width of the SRI responder port
// ----------------------------------------------------------------------------
package riscv_dm_pkg;

    localparam int unsigned SRI_DATA_WIDTH = 64;
    localparam int unsigned SRI_BE_WIDTH   = SRI_DATA_WIDTH / 8;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } sri_bridge_state_t;

endpackage

// File: rtl/riscv_dm_axil_sri_bridge.sv
// ----------------------------------------------------------------------------
// riscv_dm_axil_sri_bridge
// AXI4-Lite slave that turns single AXI reads/writes into accesses on the
// Debug Module's SRI responder port (progbuf/data/flags window). One
// transaction is in flight at a time; the SRI has a fixed one-cycle latency.
// Addresses outside the window are answered with DECERR and never reach SRI.
//
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*          AXI4-Lite write address, data and response
//   s_ar*/s_r*               AXI4-Lite read address and data/response
//   sri_addr_o/sri_en_o/sri_we_o/sri_wdata_o/sri_be_o
//                            registered SRI request, sri_en_o one cycle wide
//   sri_rdata_i/sri_error_i  SRI reply, valid the cycle after sri_en_o
// ----------------------------------------------------------------------------
module riscv_dm_axil_sri_bridge
    import riscv_dm_pkg::*;
#(
    parameter int unsigned               AXI_ADDR_WIDTH = 20,
    parameter int unsigned               AXI_DATA_WIDTH = 64,
    parameter int unsigned               SRI_ADDR_WIDTH = 6,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    input  logic [63:0]               s_wdata_i,
    input  logic [7:0]                s_wstrb_i,
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    output logic [1:0]                s_bresp_o,

    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
    output logic                      s_rvalid_o,
    input  logic                      s_rready_i,
    output logic [63:0]               s_rdata_o,
    output logic [1:0]                s_rresp_o,

    output logic [SRI_ADDR_WIDTH-1:0] sri_addr_o,
    output logic                      sri_en_o,
    output logic                      sri_we_o,
    output logic [63:0]               sri_wdata_o,
    output logic [7:0]                sri_be_o,
    input  logic [63:0]               sri_rdata_i,
    input  logic                      sri_error_i
);

    // The SRI port is a fixed 64-bit interface and the window base must be
    // aligned to the window size, otherwise the decode below is meaningless.
    if (AXI_DATA_WIDTH != SRI_DATA_WIDTH) begin : g_bad_data_width
        $error("riscv_dm_axil_sri_bridge: AXI_DATA_WIDTH must be 64");
    end
    if (BASE_ADDR[SRI_ADDR_WIDTH-1:0] != '0) begin : g_bad_base_addr
        $error("riscv_dm_axil_sri_bridge: BASE_ADDR must be window aligned");
    end

    sri_bridge_state_t         state;
    sri_bridge_state_t         state_next;

    // prio_wr set means the write side wins the next contended grant.
    logic                      prio_wr;
    logic                      kind_wr;
    axi_resp_t                 resp_q;
    logic [63:0]               rdata_q;

    logic                      wr_cand;
    logic                      rd_cand;
    logic                      grant_wr;
    logic                      grant_rd;
    logic                      grant;
    logic [AXI_ADDR_WIDTH-1:0] grant_addr;
    logic                      grant_hit;
    axi_resp_t                 cap_resp;
    logic [63:0]               cap_rdata;
    logic                      resp_phase;
    logic                      handshake;

    // Arbitration: an AW without its W (or the reverse) is not a candidate,
    // so it cannot hold off a pending read. Readys are only ever offered in
    // IDLE and never while reset is being applied.
    assign wr_cand  = s_awvalid_i & s_wvalid_i;
    assign rd_cand  = s_arvalid_i;
    assign grant_wr = (state == IDLE) & rstn_i & wr_cand & (~rd_cand | prio_wr);
    assign grant_rd = (state == IDLE) & rstn_i & rd_cand & (~wr_cand | ~prio_wr);
    assign grant    = grant_wr | grant_rd;

    assign grant_addr = grant_wr ? s_awaddr_i : s_araddr_i;
    assign grant_hit  = (grant_addr[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH] ==
                         BASE_ADDR[AXI_ADDR_WIDTH-1:SRI_ADDR_WIDTH]);

    // The SRI reply is only valid during CAPTURE; an errored access never
    // leaks the responder's data.
    assign cap_resp  = sri_error_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign cap_rdata = sri_error_i ? 64'd0 : sri_rdata_i;

    // The response is presented straight from the SRI reply in CAPTURE so a
    // hit answers two cycles after the address handshake; RESP then replays
    // the copy latched at the end of CAPTURE while the master stalls.
    assign resp_phase = (state == CAPTURE) | (state == RESP);
    assign handshake  = (s_bvalid_o & s_bready_i) | (s_rvalid_o & s_rready_i);

    // Next-state logic and the combinational AXI channel outputs.
    always_comb begin
        state_next  = state;
        s_awready_o = grant_wr;
        s_wready_o  = grant_wr;
        s_arready_o = grant_rd;
        s_bvalid_o  = resp_phase & kind_wr;
        s_rvalid_o  = resp_phase & ~kind_wr;
        s_bresp_o   = resp_q;
        s_rresp_o   = resp_q;
        s_rdata_o   = rdata_q;

        if (state == CAPTURE) begin
            s_bresp_o = cap_resp;
            s_rresp_o = cap_resp;
            s_rdata_o = cap_rdata;
        end

        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = grant_hit ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = handshake ? IDLE : RESP;
            end
            RESP: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, request latches and the response holding registers.
    // The SRI request fields are loaded at grant time so they are already
    // stable when sri_en_o rises in ISSUE.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            prio_wr     <= 1'b1;
            kind_wr     <= 1'b0;
            resp_q      <= AXI_RESP_OKAY;
            rdata_q     <= '0;
            sri_addr_o  <= '0;
            sri_en_o    <= 1'b0;
            sri_we_o    <= 1'b0;
            sri_wdata_o <= '0;
            sri_be_o    <= '0;
        end else begin
            state    <= state_next;
            sri_en_o <= grant & grant_hit;

            if (grant) begin
                prio_wr     <= grant_rd;
                kind_wr     <= grant_wr;
                sri_we_o    <= grant_wr;
                sri_addr_o  <= grant_addr[SRI_ADDR_WIDTH-1:0];
                sri_wdata_o <= grant_wr ? s_wdata_i : 64'd0;
                sri_be_o    <= grant_wr ? s_wstrb_i : 8'hFF;
                if (!grant_hit) begin
                    resp_q  <= AXI_RESP_DECERR;
                    rdata_q <= '0;
                end
            end

            if (state == CAPTURE) begin
                resp_q  <= cap_resp;
                rdata_q <= cap_rdata;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dm_axil_sri_bridge.sv
// ----------------------------------------------------------------------------
// tb_riscv_dm_axil_sri_bridge
// Self-checking bench for the AXI4-Lite to SRI bridge. A small debug-memory
// responder answers SRI accesses; a word-array reference model predicts the
// AXI responses, arbitration order, SRI request fields and latencies.
// ----------------------------------------------------------------------------
module tb_riscv_dm_axil_sri_bridge;

    logic        clk;
    logic        rstn;
    logic        s_awvalid_i, s_awready_o;
    logic [19:0] s_awaddr_i;
    logic        s_wvalid_i, s_wready_o;
    logic [63:0] s_wdata_i;
    logic [7:0]  s_wstrb_i;
    logic        s_bvalid_o, s_bready_i;
    logic [1:0]  s_bresp_o;
    logic        s_arvalid_i, s_arready_o;
    logic [19:0] s_araddr_i;
    logic        s_rvalid_o, s_rready_i;
    logic [63:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic [5:0]  sri_addr_o;
    logic        sri_en_o, sri_we_o;
    logic [63:0] sri_wdata_o;
    logic [7:0]  sri_be_o;
    logic [63:0] sri_rdata_i;
    logic        sri_error_i;

    riscv_dm_axil_sri_bridge dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_awaddr_i  (s_awaddr_i),
        .s_wvalid_i  (s_wvalid_i),
        .s_wready_o  (s_wready_o),
        .s_wdata_i   (s_wdata_i),
        .s_wstrb_i   (s_wstrb_i),
        .s_bvalid_o  (s_bvalid_o),
        .s_bready_i  (s_bready_i),
        .s_bresp_o   (s_bresp_o),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_araddr_i  (s_araddr_i),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .sri_addr_o  (sri_addr_o),
        .sri_en_o    (sri_en_o),
        .sri_we_o    (sri_we_o),
        .sri_wdata_o (sri_wdata_o),
        .sri_be_o    (sri_be_o),
        .sri_rdata_i (sri_rdata_i),
        .sri_error_i (sri_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Debug memory behind the SRI port, and the bench's own expectation of it.
    logic [63:0] dm_mem  [8];
    logic [63:0] exp_mem [8];
    logic        err_next = 1'b0;
    int          pulses   = 0;

    // Pending AXI master requests.
    bit          wr_pend = 0;
    bit          rd_pend = 0;
    logic [19:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic [19:0] rd_addr;
    bit          exp_prio_wr = 1;

    // Debug-memory responder: reply one cycle after each sri_en_o, garbage
    // at all other times so only the CAPTURE sample can be trusted.
    always @(posedge clk) begin
        if (sri_en_o) begin
            pulses = pulses + 1;
            sri_error_i <= err_next;
            if (err_next) begin
                sri_rdata_i <= {$urandom, $urandom};
            end else begin
                sri_rdata_i <= dm_mem[sri_addr_o[5:3]];
                if (sri_we_o) begin
                    for (int b = 0; b < 8; b++) begin
                        if (sri_be_o[b]) dm_mem[sri_addr_o[5:3]][8*b +: 8] <= sri_wdata_o[8*b +: 8];
                    end
                end
            end
        end else begin
            sri_rdata_i <= {$urandom, $urandom};
            sri_error_i <= 1'($urandom_range(0, 1));
        end
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input bit is_wr, input logic [1:0] e_resp, input logic [63:0] e_rdata);
        check_output("readys_busy", {s_awready_o, s_wready_o, s_arready_o}, 0);
        if (is_wr) begin
            check_output("bvalid", s_bvalid_o, 1);
            check_output("rvalid_idle", s_rvalid_o, 0);
            check_output("bresp", s_bresp_o, e_resp);
        end else begin
            check_output("rvalid", s_rvalid_o, 1);
            check_output("bvalid_idle", s_bvalid_o, 0);
            check_output("rresp", s_rresp_o, e_resp);
            check_output("rdata", s_rdata_o, e_rdata);
        end
    endtask

    // Presents the pending requests, waits for a grant, then follows the
    // granted transaction through to its response handshake. Entered and
    // left just after a falling edge.
    task automatic apply_stimulus(input bit err, input int hold);
        bit          is_wr, hit;
        logic [19:0] addr;
        logic [1:0]  e_resp;
        logic [63:0] e_rdata;
        int          p0, waited;

        s_awvalid_i = wr_pend;
        s_wvalid_i  = wr_pend;
        s_awaddr_i  = wr_addr;
        s_wdata_i   = wr_data;
        s_wstrb_i   = wr_strb;
        s_arvalid_i = rd_pend;
        s_araddr_i  = rd_addr;
        err_next    = err;
        waited      = 0;
        #1;
        while (!(s_awready_o || s_arready_o) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) begin
            check_output("grant_timeout", 0, 1);
            s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
            wr_pend = 0; rd_pend = 0;
            return;
        end

        is_wr = s_awready_o;
        check_output("wready_pair", s_wready_o, s_awready_o);
        check_output("ready_excl", s_awready_o & s_arready_o, 0);
        if (wr_pend && rd_pend) check_output("grant_wr", is_wr, exp_prio_wr);
        exp_prio_wr = !is_wr;

        addr = is_wr ? wr_addr : rd_addr;
        hit  = (addr[19:6] == 14'd0);
        e_rdata = 64'd0;
        if (!hit) e_resp = 2'b11;
        else if (err) e_resp = 2'b10;
        else begin
            e_resp = 2'b00;
            if (is_wr) begin
                for (int b = 0; b < 8; b++)
                    if (wr_strb[b]) exp_mem[addr[5:3]][8*b +: 8] = wr_data[8*b +: 8];
            end else begin
                e_rdata = exp_mem[addr[5:3]];
            end
        end
        p0 = pulses;

        @(posedge clk);
        @(negedge clk);
        if (is_wr) begin s_awvalid_i = 0; s_wvalid_i = 0; wr_pend = 0; end
        else begin s_arvalid_i = 0; rd_pend = 0; end
        #1;
        check_output("sri_en_t1", sri_en_o, hit);
        if (hit) begin
            check_output("sri_addr", sri_addr_o, addr[5:0]);
            check_output("sri_we", sri_we_o, is_wr);
            check_output("sri_be", sri_be_o, is_wr ? wr_strb : 8'hFF);
            if (is_wr) check_output("sri_wdata", sri_wdata_o, wr_data);
            check_output("readys_issue", {s_awready_o, s_wready_o, s_arready_o}, 0);
            check_output("valid_issue", s_bvalid_o | s_rvalid_o, 0);
            @(negedge clk);
            #1;
            check_output("sri_en_t2", sri_en_o, 0);
        end

        for (int i = 0; i < hold; i++) begin
            check_resp(is_wr, e_resp, e_rdata);
            @(negedge clk);
            #1;
        end
        if (is_wr) s_bready_i = 1; else s_rready_i = 1;
        #1;
        check_resp(is_wr, e_resp, e_rdata);
        @(posedge clk);
        @(negedge clk);
        s_bready_i = 0;
        s_rready_i = 0;
        #1;
        check_output("valid_done", {s_bvalid_o, s_rvalid_o}, 0);
        check_output("sri_pulses", pulses - p0, hit);
    endtask

    function automatic logic [19:0] rand_addr();
        logic [13:0] hi;
        hi = 14'($urandom_range(1, 16383));
        if ($urandom_range(0, 9) < 7) return {14'd0, 6'($urandom_range(0, 63))};
        return {hi, 6'($urandom_range(0, 63))};
    endfunction

    initial begin
        rstn = 0;
        s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
        s_awaddr_i = 0; s_wdata_i = 0; s_wstrb_i = 0; s_araddr_i = 0;
        s_bready_i = 0; s_rready_i = 0;
        for (int i = 0; i < 8; i++) begin
            dm_mem[i]  = {$urandom, $urandom};
            exp_mem[i] = dm_mem[i];
        end
        dm_mem[2]  = 64'h1234;
        exp_mem[2] = 64'h1234;

        // Reset values, with a read request present that must not be taken.
        repeat (3) @(negedge clk);
        s_arvalid_i = 1;
        #1;
        check_output("rst_readys", {s_awready_o, s_wready_o, s_arready_o}, 0);
        check_output("rst_valids", {s_bvalid_o, s_rvalid_o}, 0);
        check_output("rst_sri_en_we", {sri_en_o, sri_we_o}, 0);
        check_output("rst_resp", {s_bresp_o, s_rresp_o}, 0);
        check_output("rst_rdata", s_rdata_o, 0);
        check_output("rst_sri_fields", {sri_addr_o, sri_be_o}, 0);
        check_output("rst_sri_wdata", sri_wdata_o, 0);
        s_arvalid_i = 0;
        @(negedge clk);
        rstn = 1;

        // Directed vectors: write hit, read hit, SRI error, window miss.
        wr_pend = 1; wr_addr = 20'h00008; wr_data = 64'hDEAD_BEEF_0000_0013; wr_strb = 8'h0F;
        apply_stimulus(0, 0);
        rd_pend = 1; rd_addr = 20'h00010;
        apply_stimulus(0, 1);
        rd_pend = 1; rd_addr = 20'h00018;
        apply_stimulus(1, 0);
        rd_pend = 1; rd_addr = 20'h00040;
        apply_stimulus(0, 2);

        // AW alone is never accepted and does not block a read.
        s_awvalid_i = 1; s_wvalid_i = 0; s_awaddr_i = 20'h00020;
        repeat (2) begin
            #1;
            check_output("aw_alone", {s_awready_o, s_wready_o}, 0);
            @(negedge clk);
        end
        s_arvalid_i = 1; s_araddr_i = 20'h00020;
        #1;
        check_output("aw_no_block", {s_awready_o, s_arready_o}, 2'b01);
        s_awvalid_i = 0; s_arvalid_i = 0;
        @(negedge clk);

        // Four back-to-back contended transactions alternate W,R,W,R.
        wr_pend = 1; rd_pend = 1;
        wr_addr = 20'h00000; wr_data = {$urandom, $urandom}; wr_strb = 8'hFF; rd_addr = 20'h00028;
        for (int k = 0; k < 4; k++) begin
            check_output("rr_order", exp_prio_wr, (k % 2 == 0));
            apply_stimulus(0, 0);
            if (!wr_pend) begin wr_pend = 1; wr_addr = {14'd0, 6'($urandom_range(0, 63))}; wr_data = {$urandom, $urandom}; wr_strb = 8'($urandom); end
            if (!rd_pend) begin rd_pend = 1; rd_addr = {14'd0, 6'($urandom_range(0, 63))}; end
        end

        // Backpressure: response held for five cycles.
        apply_stimulus(0, 5);
        while (wr_pend || rd_pend) apply_stimulus(0, 0);

        // Reset while the bridge waits in CAPTURE.
        s_arvalid_i = 1; s_araddr_i = 20'h00018; err_next = 0;
        #1;
        check_output("rst_txn_grant", s_arready_o, 1);
        @(negedge clk);
        s_arvalid_i = 0;
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        #1;
        check_output("rst_mid_valids", {s_bvalid_o, s_rvalid_o}, 0);
        check_output("rst_mid_readys", {s_awready_o, s_wready_o, s_arready_o}, 0);
        check_output("rst_mid_sri_en", sri_en_o, 0);
        rstn = 1;
        exp_prio_wr = 1;
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            if (!wr_pend && $urandom_range(0, 1) == 1) begin
                wr_pend = 1; wr_addr = rand_addr(); wr_data = {$urandom, $urandom}; wr_strb = 8'($urandom);
            end
            if (!rd_pend && ($urandom_range(0, 1) == 1 || !wr_pend)) begin
                rd_pend = 1; rd_addr = rand_addr();
            end
            apply_stimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
